uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin, frame-locking arbiter that lets N byte-stream producers share one UART transmitter. It sits between the producers (command responders, debug/status reporters) and the single `uart_tx` stream input. A grant is held for a whole frame so bytes from different producers never interleave. A frame ends on an end-of-frame byte, on a length limit, or on a stall timeout.

## Interface
- `N`, default 4: number of requesters, legal range 2..8.
- `EOF`, default 8'h0A: byte value that terminates a frame.
- `MAX_LEN`, default 64: maximum bytes per frame. The grant is released after this many bytes even without `EOF`. Legal range ≥1.
- `TIMEOUT`, default 1024: stall cycles tolerated inside a frame. 0 disables the timeout.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  N  per-requester byte valid.
- `in_ready`  out  N  per-requester ready; at most one bit high at any time.
- `in_data`  in  8·N  requester k's byte on bits [8k+7:8k].
- `out_valid`  out  1  byte valid toward `uart_tx`.
- `out_ready`  in  1  `uart_tx` accepts the byte.
- `out_data`  out  8  byte toward `uart_tx`.
- `out_last`  out  1  qualifies the current `out_valid` beat as the final byte of the frame.
- `grant_id`  out  $clog2(N)  index of the current owner; valid while `busy`.
- `busy`  out  1  a frame is locked.
- `timeout_evt`  out  1  one-cycle pulse when a frame is aborted by the stall timeout.

## Operation
- State machine with two states, IDLE and LOCK. The current state is reflected on `busy`.
- **IDLE**
  - `in_ready` = 0 and `out_valid` = 0 for all requesters; `out_data` = 0.
  - If any `in_valid` is high, register the winner into `grant_id` and go to LOCK.
  - Round-robin winner: the first set bit searching from `last+1` modulo N, where `last` is the previous owner.
- **LOCK**, with owner g:
  - `out_valid` = `in_valid[g]`.
  - `out_data` = `in_data[8g+:8]`.
  - `in_ready[g]` = `out_ready`; all other `in_ready` bits are 0.
  - The path is purely combinational: no added latency and no byte buffer.
- **Transfer:** a transfer is `out_valid && out_ready`. Each transfer increments the length counter `len`, which has width $clog2(MAX_LEN+1) and is cleared on entry to LOCK.
- **Frame end:** a transfer with `out_data == EOF`, or a transfer with `len == MAX_LEN-1`.
  - `out_last` = 1 combinationally on that beat.
  - The next state is IDLE and `last` <= g.
- **Stall counter:**
  - Increments each LOCK cycle with `in_valid[g]` = 0.
  - Clears on any cycle with `in_valid[g]` = 1, and on entry to LOCK.
  - When it reaches `TIMEOUT`:
    - pulse `timeout_evt` for one cycle;
    - go to IDLE;
    - set `last` <= g;
    - the partial frame is abandoned and no `out_last` is issued.
- A requester holding `in_valid` must keep `in_data` stable until `in_ready`. Dropping `in_valid` mid-frame is legal; the timeout covers it.
- Non-owners are never stalled indirectly; they simply see `in_ready` = 0.

## Timing
- **Reset values:**
  - state IDLE; `busy`, `out_valid`, `out_last`, `timeout_evt` = 0;
  - `in_ready` = 0; `grant_id` = 0; `out_data` = 0; counters = 0;
  - `last` = N-1, so requester 0 has first priority after reset.
- **Arbitration latency:** a request seen in IDLE at edge t gives `busy` = 1 and `grant_id` valid after edge t; the first transfer is possible in cycle t+1.
- **Inter-frame gap:** at least one IDLE cycle between frames. A frame ending at edge t allows the next grant at edge t+1, with data from cycle t+2.
- **Throughput inside a frame:** one byte per cycle when `out_ready` is held high.
- **Simultaneous events:**
  - `EOF` byte on the `MAX_LEN` boundary: a single frame end.
  - Timeout threshold on the same cycle as a transfer: the transfer wins and the stall counter clears.
- **Only one requester:** it is re-granted after each one-cycle IDLE gap.
- **Reset mid-frame:** outputs go to reset values immediately (asynchronous). The partial frame is dropped and no `out_last` is issued.
- **`TIMEOUT` = 0:** the stall counter is unused and `timeout_evt` stays 0.

## Test plan
- **Single frame:** requester 2 sends 8'h41, 8'h42, 8'h0A with `out_ready` = 1.
  - `grant_id` = 2 one cycle after request; three consecutive transfers.
  - `out_last` = 1 on 8'h0A only; `busy` = 0 the next cycle.
- **Fairness:** all four requesters continuously send 1-byte frames (8'h0A).
  - Grant order is 0, 1, 2, 3, 0, … after reset.
  - Exactly one IDLE cycle between frames; no `in_ready` bit is ever high for two requesters.
- **Length limit:** with `MAX_LEN` = 4, requester 1 streams 8'h55 continuously.
  - `out_last` on the 4th byte; the grant is released.
  - Requester 1 is re-granted only after the other pending requesters are served.
- **Backpressure:** `out_ready` toggles 1, 0, 0, 1 during a frame.
  - `in_ready[g]` follows `out_ready` exactly.
  - `out_data` is stable while stalled; no byte is lost or duplicated.
- **Timeout:** with `TIMEOUT` = 16, requester 0 sends one byte, drops `in_valid` for 16 cycles, while requester 3 is pending.
  - `timeout_evt` pulses once; `out_last` is never asserted.
  - `grant_id` = 3 two cycles later.
- **Reset mid-frame:** assert `rst` after 2 bytes of a frame.
  - All outputs go to 0 asynchronously.
  - After release, requester 0 wins if requesting with others.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locking arbiter that lets N byte producers share one uart_tx input.
// A grant is held until an EOF byte, the MAX_LEN limit, or a stall timeout ends the frame.
module uart_tx_arbiter #(
  parameter int         N       = 4,
  parameter logic [7:0] EOF     = 8'h0A,
  parameter int         MAX_LEN = 64,
  parameter int         TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [8*N-1:0]       in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout_evt
);

  localparam int GW = $clog2(N);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]    state;
  logic [GW-1:0] last;
  logic [GW-1:0] winner;
  logic          any_req;
  logic [LW-1:0] len;
  logic [SW-1:0] stall;
  logic          owner_valid;
  logic [7:0]    owner_data;
  logic          xfer;
  logic          frame_end;
  logic          stall_hit;

  assign any_req = |in_valid;

  // Round-robin search starting one past the previous owner, wrapping modulo N.
  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    idx    = 0;
    winner = '0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      for (int k = 0; k < N; k++) begin
        if (!found && (k == idx) && in_valid[k]) begin
          found  = 1'b1;
          winner = GW'(k);
        end
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = 8'h00;
    for (int k = 0; k < N; k++) begin
      if (grant_id == GW'(k)) begin
        owner_valid = in_valid[k];
        owner_data  = in_data[8*k +: 8];
      end
    end
  end

  assign busy      = (state == ST_LOCK);
  assign out_valid = busy && owner_valid;
  assign out_data  = busy ? owner_data : 8'h00;

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = busy && (grant_id == GW'(k)) && out_ready;
    end
  end

  assign xfer      = out_valid && out_ready;
  assign frame_end = xfer && ((owner_data == EOF) || (len == LW'(MAX_LEN - 1)));
  assign out_last  = frame_end;

  // The threshold is checked on the stall cycle that would bring the counter to TIMEOUT.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign stall_hit = busy && !owner_valid && (stall == SW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign stall_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_id    <= '0;
      last        <= GW'(N - 1);
      len         <= '0;
      stall       <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state    <= ST_LOCK;
            grant_id <= winner;
            len      <= '0;
            stall    <= '0;
          end
        end
        ST_LOCK: begin
          if (xfer) begin
            len <= len + LW'(1);
          end
          if (owner_valid) begin
            stall <= '0;
          end else if (TIMEOUT > 0) begin
            stall <= stall + SW'(1);
          end
          if (frame_end) begin
            state <= ST_IDLE;
            last  <= grant_id;
          end else if (stall_hit) begin
            state       <= ST_IDLE;
            last        <= grant_id;
            timeout_evt <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester expected bytes are queued when
// stimulus is loaded and popped by a monitor on every accepted output beat.
module tb_uart_tx_arbiter;

  localparam int         NR    = 4;
  localparam logic [7:0] EOF_B = 8'h0A;
  localparam int         MLEN  = 4;
  localparam int         TOUT  = 16;

  logic          clk;
  logic          rst;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_evt;

  int checks;
  int failures;

  logic [7:0] src_q[4][$];
  logic [8:0] sb_q[4][$];
  int         pos[4];
  logic       rdy_pat[$];

  logic       s_busy, s_ov, s_or, s_ol, s_te;
  logic [1:0] s_gid;
  logic [7:0] s_od;
  logic [3:0] s_ir;

  uart_tx_arbiter #(
    .N(NR), .EOF(EOF_B), .MAX_LEN(MLEN), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .grant_id(grant_id), .busy(busy),
    .timeout_evt(timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted beat must match the head of its owner's expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(in_ready)) begin
        failures++;
        $display("[TB] FAIL in_ready_onehot: got %b, expected at most one bit set", in_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q[grant_id].size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_unexpected: got byte %h from %0d, expected no byte", out_data, grant_id);
        end else begin
          logic [8:0] e;
          e = sb_q[grant_id].pop_front();
          if ({out_last, out_data} !== e) begin
            failures++;
            $display("[TB] FAIL sb_beat: got last=%b data=%h from %0d, expected last=%b data=%h",
                     out_last, out_data, grant_id, e[8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic push_byte(input int k, input logic [7:0] b);
    logic lst;
    pos[k]++;
    lst = (b == EOF_B) || (pos[k] == MLEN);
    if (lst) pos[k] = 0;
    src_q[k].push_back(b);
    sb_q[k].push_back({lst, b});
  endtask

  task automatic load_inputs();
    for (int k = 0; k < NR; k++) begin
      if (src_q[k].size() > 0) begin
        in_valid[k]       = 1'b1;
        in_data[8*k +: 8] = src_q[k][0];
      end else begin
        in_valid[k]       = 1'b0;
        in_data[8*k +: 8] = 8'h00;
      end
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < NR; k++) begin
      src_q[k].delete();
      sb_q[k].delete();
      pos[k] = 0;
    end
    rdy_pat.delete();
  endtask

  // One clock: snapshot outputs mid-cycle, then retire accepted bytes after the edge.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc    = in_valid & in_ready;
    s_busy = busy;  s_gid = grant_id; s_ov = out_valid; s_or = out_ready;
    s_ol   = out_last; s_od = out_data; s_te = timeout_evt; s_ir = in_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (acc[k]) void'(src_q[k].pop_front());
    end
    out_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    load_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    load_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({busy, out_valid, out_last, timeout_evt} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got busy/ov/last/te=%b, expected 0000",
               {busy, out_valid, out_last, timeout_evt});
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 0000", in_ready);
    end
    checks++;
    if (grant_id !== 2'd0 || out_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_gid_data: got gid=%0d data=%h, expected gid=0 data=00", grant_id, out_data);
    end
    rst = 1'b0;
    step();
    checks++;
    if (s_busy !== 1'b0 || s_ov !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got busy=%b ov=%b, expected 0 0", s_busy, s_ov);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_d[3];
    exp_d = '{8'h41, 8'h42, 8'h0A};
    for (int i = 0; i < 3; i++) push_byte(2, exp_d[i]);
    load_inputs();
    step();
    checks++;
    if (s_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_req_cycle: got busy=%b, expected 0", s_busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_busy !== 1'b1 || s_gid !== 2'd2 || !(s_ov && s_or) || s_od !== exp_d[i]
          || s_ol !== (i == 2)) begin
        failures++;
        $display("[TB] FAIL single_beat%0d: got busy=%b gid=%0d xfer=%b data=%h last=%b, expected 1 2 1 %h %b",
                 i, s_busy, s_gid, s_ov && s_or, s_od, s_ol, exp_d[i], (i == 2));
      end
    end
    step();
    checks++;
    if (s_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_release: got busy=%b, expected 0", s_busy);
    end
  endtask

  task automatic test_fairness();
    int n, prev, cyc;
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NR; k++) push_byte(k, 8'h0A);
    load_inputs();
    n = 0; prev = 0; cyc = 0;
    while (n < 12 && cyc < 100) begin
      step();
      cyc++;
      if (s_ov && s_or) begin
        checks++;
        if (s_gid !== 2'(n % 4)) begin
          failures++;
          $display("[TB] FAIL fair_order%0d: got gid=%0d, expected %0d", n, s_gid, n % 4);
        end
        if (n > 0) begin
          checks++;
          if (cyc - prev != 2) begin
            failures++;
            $display("[TB] FAIL fair_gap%0d: got %0d cycles, expected 2", n, cyc - prev);
          end
        end
        prev = cyc;
        n++;
      end
    end
    checks++;
    if (n != 12) begin
      failures++;
      $display("[TB] FAIL fair_budget: got %0d frames, expected 12", n);
    end
  endtask

  task automatic test_length_limit();
    int exp_g[10];
    logic exp_l[10];
    int n, cyc;
    exp_g = '{0, 1, 1, 1, 1, 2, 1, 1, 1, 1};
    exp_l = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    push_byte(0, 8'h0A);
    for (int i = 0; i < 8; i++) push_byte(1, 8'h55);
    push_byte(2, 8'h0A);
    load_inputs();
    n = 0; cyc = 0;
    while (n < 10 && cyc < 80) begin
      step();
      cyc++;
      if (s_ov && s_or) begin
        checks++;
        if (s_gid !== 2'(exp_g[n]) || s_ol !== exp_l[n]) begin
          failures++;
          $display("[TB] FAIL len_beat%0d: got gid=%0d last=%b, expected gid=%0d last=%b",
                   n, s_gid, s_ol, exp_g[n], exp_l[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 10) begin
      failures++;
      $display("[TB] FAIL len_budget: got %0d beats, expected 10", n);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d[6];
    logic       exp_r[6];
    exp_d = '{8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'h0A};
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    push_byte(3, 8'hA1); push_byte(3, 8'hA2); push_byte(3, 8'hA3); push_byte(3, 8'h0A);
    for (int i = 0; i < 6; i++) rdy_pat.push_back(exp_r[i]);
    load_inputs();
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (s_busy !== 1'b1 || s_gid !== 2'd3 || s_od !== exp_d[i] || s_ir !== {s_or, 3'b000}
          || s_or !== exp_r[i] || s_ol !== (i == 5)) begin
        failures++;
        $display("[TB] FAIL bp_cycle%0d: got gid=%0d data=%h ready=%b in_ready=%b last=%b, expected 3 %h %b %b %b",
                 i, s_gid, s_od, s_or, s_ir, s_ol, exp_d[i], exp_r[i], {exp_r[i], 3'b000}, (i == 5));
      end
    end
    step();
    checks++;
    if (s_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_release: got busy=%b, expected 0", s_busy);
    end
  endtask

  task automatic test_timeout();
    int cyc, stalls, last_stall, te_cnt, te_at, g3_at, ol_bad;
    push_byte(0, 8'h41);
    push_byte(3, 8'h0A);
    load_inputs();
    cyc = 0; stalls = 0; last_stall = -10; te_cnt = 0; te_at = -1; g3_at = -1; ol_bad = 0;
    while (cyc < 60 && (g3_at < 0 || cyc < g3_at + 2)) begin
      step();
      cyc++;
      if (s_busy && s_gid == 2'd0 && !s_ov) begin
        stalls++;
        last_stall = cyc;
      end
      if (s_busy && s_gid == 2'd0 && s_ol) ol_bad++;
      if (s_te) begin
        te_cnt++;
        te_at = cyc;
      end
      if (s_busy && s_gid == 2'd3 && g3_at < 0) g3_at = cyc;
    end
    pos[0] = 0;
    checks++;
    if (stalls != TOUT) begin
      failures++;
      $display("[TB] FAIL to_stalls: got %0d stall cycles, expected %0d", stalls, TOUT);
    end
    checks++;
    if (te_cnt != 1 || te_at != last_stall + 1) begin
      failures++;
      $display("[TB] FAIL to_pulse: got %0d pulses at offset %0d, expected 1 at offset 1",
               te_cnt, te_at - last_stall);
    end
    checks++;
    if (g3_at != last_stall + 2) begin
      failures++;
      $display("[TB] FAIL to_regrant: got gid3 at offset %0d, expected 2", g3_at - last_stall);
    end
    checks++;
    if (ol_bad != 0) begin
      failures++;
      $display("[TB] FAIL to_no_last: got %0d out_last beats, expected 0", ol_bad);
    end
  endtask

  task automatic test_reset_midframe();
    int n, cyc, first_gid;
    push_byte(2, 8'h21); push_byte(2, 8'h22); push_byte(2, 8'h23); push_byte(2, 8'h0A);
    load_inputs();
    n = 0; cyc = 0;
    while (n < 2 && cyc < 10) begin
      step();
      cyc++;
      if (s_ov && s_or) n++;
    end
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rm_prestate: got busy=%b ov=%b, expected 1 1", busy, out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, out_last, timeout_evt} !== 4'b0000 || in_ready !== 4'b0000
        || grant_id !== 2'd0 || out_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL rm_async: got busy/ov/last/te=%b in_ready=%b gid=%0d data=%h, expected all 0",
               {busy, out_valid, out_last, timeout_evt}, in_ready, grant_id, out_data);
    end
    clear_all();
    push_byte(0, 8'h0A); push_byte(1, 8'h0A); push_byte(2, 8'h0A);
    load_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0; cyc = 0; first_gid = -1;
    while (n < 3 && cyc < 20) begin
      step();
      cyc++;
      if (s_ov && s_or) begin
        if (n == 0) first_gid = int'(s_gid);
        n++;
      end
    end
    checks++;
    if (first_gid != 0) begin
      failures++;
      $display("[TB] FAIL rm_first_grant: got gid=%0d, expected 0", first_gid);
    end
    step();
    checks++;
    if (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d bytes outstanding, expected 0",
               sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size());
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    clear_all();
    test_reset();
    test_single_frame();
    test_fairness();
    test_length_limit();
    test_backpressure();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
